// File: rtl/wallace_mac_accum_pkg.sv
// Shared constants and state encoding for the Wallace MAC accumulator slice.
package wallace_mac_accum_pkg;

  // Product width of the 4x4 Wallace multiplier feeding this stage.
  localparam int WM_PROD_W = 8;

  // Frame FSM encoding; 2'd3 is unused and recovers to WM_IDLE.
  typedef enum logic [1:0] {
    WM_IDLE  = 2'd0,
    WM_ACCUM = 2'd1,
    WM_HOLD  = 2'd2
  } wm_state_t;

  // Beat counter width large enough to hold max_beats itself.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/wallace_mac_accum_if.sv
// Stream bundle for the MAC accumulator: product beats in, frame result out.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. A source holds valid and its payload stable until that edge;
// ready may change freely and is never a function of valid.
interface wallace_mac_accum_if
  import wallace_mac_accum_pkg::*;
#(
  parameter int PROD_W = WM_PROD_W,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  // Accumulator side.
  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

  // Producer / consumer side.
  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/wallace_mac_addsat.sv
// Combinational accumulate step: acc + zero-extended product, with carry out
// and optional clamp to all ones when the sum overflows ACC_W bits.
module wallace_mac_addsat
  import wallace_mac_accum_pkg::*;
#(
  parameter int PROD_W   = WM_PROD_W,
  parameter int ACC_W    = 16,
  parameter bit SATURATE = 1'b0
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] prod,
  output logic [ACC_W-1:0]  acc_next,
  output logic              carry
);

  logic [ACC_W:0] sum;

  // One extra bit captures the carry; saturation replaces the wrapped value.
  always_comb begin
    sum   = {1'b0, acc} + (ACC_W + 1)'(prod);
    carry = sum[ACC_W];
    if (SATURATE && carry) acc_next = '1;
    else                   acc_next = sum[ACC_W-1:0];
  end

endmodule

// File: rtl/wallace_mac_accum.sv
// Frame accumulator behind the Wallace multiplier: sums products of a frame,
// then holds sum/count/overflow until the consumer takes the result.
module wallace_mac_accum
  import wallace_mac_accum_pkg::*;
#(
  parameter int PROD_W    = WM_PROD_W,
  parameter int ACC_W     = 16,
  parameter int MAX_BEATS = 16,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                clear,
  wallace_mac_accum_if.slave  bus,
  output wm_state_t           dbg_state
);

  localparam int CNT_W = cnt_width(MAX_BEATS);

  wm_state_t        state, state_next;
  logic [ACC_W-1:0] acc, acc_sum;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic             ovf, carry;
  logic             rdy, hold, illegal, accept, closes, flush;

  assign rdy     = (state == WM_IDLE) || (state == WM_ACCUM);
  assign hold    = (state == WM_HOLD);
  assign illegal = !(state inside {WM_IDLE, WM_ACCUM, WM_HOLD});
  assign accept  = bus.in_valid & rdy;
  assign cnt_inc = cnt + 1'b1;
  // A beat closes the frame on in_last or when it is the MAX_BEATS-th beat.
  assign closes  = bus.in_last | (cnt_inc == CNT_W'(MAX_BEATS));
  // Datapath returns to zero on abort, on result handoff, or from a bad state.
  assign flush   = clear | (hold & bus.out_ready) | illegal;

  wallace_mac_addsat #(
    .PROD_W   (PROD_W),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_addsat (
    .acc      (acc),
    .prod     (bus.in_prod),
    .acc_next (acc_sum),
    .carry    (carry)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= WM_IDLE;
    else          state <= state_next;
  end

  // Next-state logic; clear overrides accepts and the result handshake.
  always_comb begin
    state_next = state;
    case (state)
      WM_IDLE, WM_ACCUM: if (accept) state_next = closes ? WM_HOLD : WM_ACCUM;
      WM_HOLD:           if (bus.out_ready) state_next = WM_IDLE;
      default:           state_next = WM_IDLE;
    endcase
    if (clear) state_next = WM_IDLE;
  end

  // Accumulator, beat counter and sticky overflow for the current frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (flush) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= acc_sum;
      cnt <= cnt_inc;
      ovf <= ovf | carry;
    end
  end

  // Result fields are only presented while the frame is held.
  assign bus.in_ready  = rdy;
  assign bus.out_valid = hold;
  assign bus.out_sum   = hold ? acc : '0;
  assign bus.out_count = hold ? cnt : '0;
  assign bus.out_ovf   = hold & ovf;
  assign dbg_state     = state;

endmodule
